// File: rtl/ccff_bitstream_loader.sv
// Streams bitstream words LSB-first into a configuration flip-flop chain.
// Optional tail CRC-8 monitor on ccff_tail is enabled with `define CCFF_TAIL_CRC_EN.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_TAIL_CRC_EN
    ,
    output logic [7:0]        tail_crc
`endif
);

    localparam int BCNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN + 1) : 1;
    localparam int WCNT_W = $clog2(WORD_W);

    localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0] LAST_WBIT = WCNT_W'(WORD_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [WORD_W-1:0] shreg_q,    shreg_d;
    logic [BCNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [WCNT_W-1:0] wbit_cnt_q, wbit_cnt_d;
    logic              start_acc;

    assign start_acc = (state_q == ST_IDLE) && start && !abort;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        wbit_cnt_d = wbit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d   = ST_LOAD;
                    bit_cnt_d = '0;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (s_valid) begin
                    shreg_d    = s_data;
                    wbit_cnt_d = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d    = shreg_q >> 1;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                wbit_cnt_d = wbit_cnt_q + 1'b1;
                // Chain-full takes priority so the tail of the last word is dropped
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else if (wbit_cnt_q == LAST_WBIT) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            wbit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            wbit_cnt_q <= wbit_cnt_d;
        end
    end

    // Outputs decode directly from state so reset clears them without a clock
    assign s_ready       = (state_q == ST_LOAD);
    assign ccff_shift_en = (state_q == ST_SHIFT);
    assign ccff_head     = ccff_shift_en & shreg_q[0];
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

`ifdef CCFF_TAIL_CRC_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (start_acc) begin
            crc_d = 8'h00;
        end else if (ccff_shift_en) begin
            crc_d = crc8_step(crc_q, ccff_tail);
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign tail_crc = crc_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: instance A (12-bit chain) and instance B (48-bit chain, stalled source).
// Tail CRC checks compile in when CCFF_TAIL_CRC_EN is defined.
module tb_ccff_bitstream_loader;

    logic clk = 1'b0;
    logic pReset = 1'b1;
    always #5 clk = ~clk;

    logic       a_start = 0, a_abort = 0, a_valid = 0, a_tail = 1;
    logic [7:0] a_data = '0;
    logic       a_ready, a_head, a_sen, a_busy, a_done;
    logic       b_start = 0, b_abort = 0, b_valid = 0, b_tail = 0;
    logic [7:0] b_data = '0;
    logic       b_ready, b_head, b_sen, b_busy, b_done;
`ifdef CCFF_TAIL_CRC_EN
    logic [7:0] a_crc, b_crc;
`endif

    ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_a (
        .prog_clk(clk), .pReset(pReset), .start(a_start), .abort(a_abort),
        .s_valid(a_valid), .s_data(a_data), .s_ready(a_ready), .ccff_head(a_head),
        .ccff_shift_en(a_sen), .ccff_tail(a_tail), .busy(a_busy), .done(a_done)
`ifdef CCFF_TAIL_CRC_EN
        , .tail_crc(a_crc)
`endif
    );

    ccff_bitstream_loader #(.CHAIN_LEN(48), .WORD_W(8)) u_b (
        .prog_clk(clk), .pReset(pReset), .start(b_start), .abort(b_abort),
        .s_valid(b_valid), .s_data(b_data), .s_ready(b_ready), .ccff_head(b_head),
        .ccff_shift_en(b_sen), .ccff_tail(b_tail), .busy(b_busy), .done(b_done)
`ifdef CCFF_TAIL_CRC_EN
        , .tail_crc(b_crc)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

`ifdef CCFF_TAIL_CRC_EN
    function automatic logic [7:0] crc_ones(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ 1'b1) ? 8'h07 : 8'h00);
        return c;
    endfunction
`endif

    // Scoreboards: expected head bits are queued at each handshake, popped per shift cycle
    logic [7:0] a_words[$], b_words[$];
    logic       a_exp[$],   b_exp[$];
    int a_rem = 0, b_rem = 0, a_shifts = 0, b_shifts = 0, a_hs = 0, b_hs = 0;
    int a_dones = 0, b_dones = 0, b_widx = 0, b_stall_at = -1, b_stall = 0;
    logic [7:0] wa, wb;

    always @(negedge clk) begin
        if (a_sen) begin
            a_shifts++;
            if (a_exp.size() == 0) check("a_unexp_shift", a_sen, 0);
            else check("a_head", a_head, a_exp.pop_front());
        end
        if (a_done) a_dones++;
        if (a_words.size() == 0) a_valid = 0;
        else begin a_valid = 1; a_data = a_words[0]; end
        if (a_valid && a_ready) begin
            a_hs++;
            wa = a_words.pop_front();
            for (int i = 0; i < 8; i++) if (a_rem > 0) begin a_exp.push_back(wa[i]); a_rem--; end
        end
    end

    always @(negedge clk) begin
        if (b_sen) begin
            b_shifts++;
            if (b_exp.size() == 0) check("b_unexp_shift", b_sen, 0);
            else check("b_head", b_head, b_exp.pop_front());
        end
        if (b_done) b_dones++;
        if (b_words.size() == 0) b_valid = 0;
        else if (b_stall > 0 && b_widx == b_stall_at) begin
            b_valid = 0;
            if (b_ready) begin check("b_stall_sen", b_sen, 0); b_stall--; end
        end else begin b_valid = 1; b_data = b_words[0]; end
        if (b_valid && b_ready) begin
            b_hs++; b_widx++;
            wb = b_words.pop_front();
            for (int i = 0; i < 8; i++) if (b_rem > 0) begin b_exp.push_back(wb[i]); b_rem--; end
        end
    end

    task automatic load_a(input logic [7:0] w0, input logic [7:0] w1);
        a_words.delete(); a_exp.delete();
        a_words.push_back(w0); a_words.push_back(w1);
        a_rem = 12;
    endtask

    task automatic wait_done(input bit use_b, input int maxc, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (((use_b ? b_done : a_done) == 1'b0) && n < maxc);
        check(tag, use_b ? b_done : a_done, 1);
    endtask

    int sh0, hs0, dn0, cnt;

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_busy", a_busy, 0); check("rst_ready", a_ready, 0);
        check("rst_sen", a_sen, 0);   check("rst_head", a_head, 0);
        check("rst_done", a_done, 0); check("rst_b_busy", b_busy, 0);
`ifdef CCFF_TAIL_CRC_EN
        check("rst_crc", a_crc, 8'h00);
`endif
        pReset = 0;

        // Reference load: 0xA5, 0x03 into 12 bits; start during SHIFT and start+abort in IDLE ignored
        @(negedge clk);
        sh0 = a_shifts; hs0 = a_hs; dn0 = a_dones;
        load_a(8'hA5, 8'h03);
        a_start = 1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            a_start = (k == 5);
            a_abort = 0;
            if (k == 16) begin a_start = 1; a_abort = 1; end
            check("t1_sen",  a_sen,  ((k >= 2 && k <= 9) || (k >= 11 && k <= 14)));
            check("t1_done", a_done, (k == 15));
            check("t1_busy", a_busy, (k <= 15));
        end
        a_start = 0; a_abort = 0;
        @(negedge clk);
        check("t1_shifts", a_shifts - sh0, 12);
        check("t1_hs", a_hs - hs0, 2);
        check("t1_dones", a_dones - dn0, 1);
        check("t1_exp_left", a_exp.size(), 0);
`ifdef CCFF_TAIL_CRC_EN
        check("t1_crc", a_crc, crc_ones(12));
`endif

        // 48-bit chain with a 5-cycle source stall before the third word
        for (int i = 0; i < 6; i++) b_words.push_back(8'($urandom_range(0, 255)));
        b_rem = 48; b_widx = 0; b_stall_at = 2; b_stall = 5;
        sh0 = b_shifts; hs0 = b_hs; dn0 = b_dones;
        b_start = 1;
        @(negedge clk);
        b_start = 0;
        wait_done(1'b1, 300, "t2_done_timeout");
        @(negedge clk);
        check("t2_shifts", b_shifts - sh0, 48);
        check("t2_hs", b_hs - hs0, 6);
        check("t2_dones", b_dones - dn0, 1);
        check("t2_stall_used", b_stall, 0);
        check("t2_exp_left", b_exp.size(), 0);

        // Abort on the third shift cycle, then a clean reload
        sh0 = a_shifts; dn0 = a_dones;
        load_a(8'h5A, 8'hC3);
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 3; c++) begin
            @(negedge clk);
            if (a_sen) cnt++;
        end
        check("t3_reached_shift3", cnt, 3);
        a_abort = 1;
        @(negedge clk);
        a_abort = 0;
        check("t3_busy", a_busy, 0); check("t3_sen", a_sen, 0); check("t3_ready", a_ready, 0);
        repeat (5) @(negedge clk);
        check("t3_no_done", a_dones - dn0, 0);
        check("t3_shifts", a_shifts - sh0, 3);
`ifdef CCFF_TAIL_CRC_EN
        check("t3_crc_held", a_crc, crc_ones(3));
`endif
        sh0 = a_shifts;
        load_a(8'h3C, 8'h0F);
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        wait_done(1'b0, 100, "t3_reload_timeout");
        @(negedge clk);
        check("t3_reload_shifts", a_shifts - sh0, 12);
        check("t3_reload_exp_left", a_exp.size(), 0);
`ifdef CCFF_TAIL_CRC_EN
        check("t3_reload_crc", a_crc, crc_ones(12));
`endif

        // Asynchronous reset mid-SHIFT clears outputs without a clock edge
        load_a(8'hFF, 8'h81);
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 4; c++) begin
            @(negedge clk);
            if (a_sen) cnt++;
        end
        check("t4_in_shift", a_sen, 1);
        #2 pReset = 1;
        #1;
        check("t4_busy", a_busy, 0); check("t4_sen", a_sen, 0); check("t4_head", a_head, 0);
        check("t4_ready", a_ready, 0); check("t4_done", a_done, 0);
`ifdef CCFF_TAIL_CRC_EN
        check("t4_crc", a_crc, 8'h00);
`endif
        @(negedge clk);
        pReset = 0;
        a_words.delete(); a_exp.delete();
        @(negedge clk);
        check("t4_idle", a_busy, 0);
        sh0 = a_shifts;
        load_a(8'h12, 8'h34);
        a_start = 1;
        @(negedge clk);
        a_start = 0;
        wait_done(1'b0, 100, "t4_reload_timeout");
        @(negedge clk);
        check("t4_reload_shifts", a_shifts - sh0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
